// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-word handshake bundle for instr_encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_opcode, out_funct
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_opcode, out_funct
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs mnemonic requests into MIPS words behind a small output FIFO
module instr_encoder #(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    instr_encoder_if.slave     bus,
    output logic               err,
    output logic [COUNT_W-1:0] emitted
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] emitted_q, emitted_d;

    logic        accept, legal, push, pop;
    logic [31:0] word;

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] w;
        w = 32'h0;
        case (op)
            4'd0: w = {6'h23, rs, rt, imm};
            4'd1: w = {6'h2b, rs, rt, imm};
            4'd2: w = {6'h00, rs, rt, rd, 5'h00, 6'h20};
            4'd3: w = {6'h08, rs, rt, imm};
            4'd4: w = {6'h00, rs, rt, rd, 5'h00, 6'h22};
            4'd5: w = {6'h00, rs, rt, rd, 5'h00, 6'h24};
            4'd6: w = {6'h00, rs, rt, rd, 5'h00, 6'h25};
            4'd7: w = {6'h00, rs, rt, rd, 5'h00, 6'h27};
            4'd8: w = {6'h00, rs, rt, rd, 5'h00, 6'h26};
            4'd9: w = {6'h04, rs, rt, imm};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Handshake flags come from registered occupancy only, so out_ready never reaches in_ready.
    assign bus.in_ready  = (count_q != FULL_COUNT);
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr  = mem_q[rd_ptr_q];
    assign bus.out_opcode = mem_q[rd_ptr_q][31:26];
    assign bus.out_funct  = mem_q[rd_ptr_q][5:0];
    assign err     = err_q;
    assign emitted = emitted_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign legal  = (bus.in_op < 4'd10);
    assign push   = accept && legal;
    assign pop    = bus.out_valid && bus.out_ready;
    assign word   = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        emitted_d = emitted_q;

        if (push) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            emitted_d = emitted_q + COUNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Illegal ops complete their handshake but only leave this sticky flag behind.
        if (accept && !legal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            emitted_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            emitted_q <= emitted_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed vector bench for instr_encoder
module tb_instr_encoder;
    logic        clock;
    logic        reset;
    logic        err;
    logic [15:0] emitted;
    int          n_checks;
    int          n_fail;
    int          exp_emitted;

    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(2), .COUNT_W(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .err     (err),
        .emitted (emitted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
    endtask

    task automatic send_one(input vec_t v, input string name);
        logic [31:0] e;
        e = v.exp_instr;
        @(negedge clock);
        bus.out_ready = 1'b1;
        check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        drive(v.op, v.rs, v.rt, v.rd, v.imm);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, " out_instr"}, bus.out_instr, e);
        check({name, " out_opcode"}, 32'(bus.out_opcode), 32'(e[31:26]));
        check({name, " out_funct"}, 32'(bus.out_funct), 32'(e[5:0]));
        exp_emitted++;
        @(negedge clock);
        check({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({name, " emitted"}, 32'(emitted), 32'(exp_emitted));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  sweep_op    [6];
        logic [5:0]  sweep_funct [6];
        logic [31:0] bp_word     [4];

        n_checks    = 0;
        n_fail      = 0;
        exp_emitted = 0;

        vecs[0] = '{4'd0, 5'd1,  5'd2,  5'd0,  16'h0004, 32'h8C220004};
        vecs[1] = '{4'd1, 5'd0,  5'd9,  5'd31, 16'hFFFC, 32'hAC09FFFC};
        vecs[2] = '{4'd3, 5'd8,  5'd8,  5'd17, 16'h0001, 32'h21080001};
        vecs[3] = '{4'd9, 5'd1,  5'd2,  5'd5,  16'hFFFF, 32'h1022FFFF};
        vecs[4] = '{4'd2, 5'd3,  5'd4,  5'd5,  16'h0000, 32'h00642820};
        vecs[5] = '{4'd2, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h03FFF820};
        vecs[6] = '{4'd0, 5'd31, 5'd0,  5'd0,  16'h8000, 32'h8FE08000};
        vecs[7] = '{4'd8, 5'd3,  5'd4,  5'd5,  16'h1234, 32'h00642826};

        sweep_op    = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        sweep_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26};
        bp_word     = '{32'h8C010001, 32'h8C010002, 32'h8C010003, 32'h8C010004};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_rs     = 5'd0;
        bus.in_rt     = 5'd0;
        bus.in_rd     = 5'd0;
        bus.in_imm    = 16'd0;
        bus.out_ready = 1'b0;
        #12;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset err", 32'(err), 32'd0);
        check("reset emitted", 32'(emitted), 32'd0);
        check("reset out_instr", bus.out_instr, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i], $sformatf("vec%0d", i));
        end

        // R-type sweep streamed back-to-back: one word must appear on every cycle.
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            bus.out_ready = 1'b1;
            if (i > 0) begin
                check($sformatf("sweep%0d out_valid", i - 1), 32'(bus.out_valid), 32'd1);
                check($sformatf("sweep%0d funct", i - 1), 32'(bus.out_funct), 32'(sweep_funct[i - 1]));
                check($sformatf("sweep%0d opcode", i - 1), 32'(bus.out_opcode), 32'd0);
                exp_emitted++;
            end
            if (i == 1) check("sweep ADD word", bus.out_instr, 32'h00642820);
            if (i < 6) drive(sweep_op[i][3:0], 5'd3, 5'd4, 5'd5, 16'h0);
            else       bus.in_valid = 1'b0;
        end
        @(negedge clock);
        check("sweep drain", 32'(bus.out_valid), 32'd0);
        check("sweep emitted", 32'(emitted), 32'(exp_emitted));

        // Backpressure: only DEPTH words fit while the consumer stalls.
        bus.out_ready = 1'b0;
        check("bp in_ready A", 32'(bus.in_ready), 32'd1);
        drive(4'd0, 5'd0, 5'd1, 5'd0, 16'h0001);
        @(negedge clock);
        check("bp in_ready B", 32'(bus.in_ready), 32'd1);
        check("bp head A", bus.out_instr, bp_word[0]);
        drive(4'd0, 5'd0, 5'd1, 5'd0, 16'h0002);
        @(negedge clock);
        check("bp full in_ready", 32'(bus.in_ready), 32'd0);
        drive(4'd0, 5'd0, 5'd1, 5'd0, 16'h0003);
        @(negedge clock);
        check("bp still full", 32'(bus.in_ready), 32'd0);
        check("bp stall stable", bus.out_instr, bp_word[0]);
        check("bp stall valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clock);
        exp_emitted++;
        check("bp head B", bus.out_instr, bp_word[1]);
        check("bp in_ready after pop", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        exp_emitted++;
        check("bp head C", bus.out_instr, bp_word[2]);
        drive(4'd0, 5'd0, 5'd1, 5'd0, 16'h0004);
        @(negedge clock);
        exp_emitted++;
        check("bp head D", bus.out_instr, bp_word[3]);
        bus.in_valid = 1'b0;
        @(negedge clock);
        exp_emitted++;
        check("bp drain", 32'(bus.out_valid), 32'd0);
        check("bp emitted", 32'(emitted), 32'(exp_emitted));

        // Illegal op between two legal ones is swallowed and latches err.
        check("illegal err before", 32'(err), 32'd0);
        drive(4'd2, 5'd3, 5'd4, 5'd5, 16'h0);
        @(negedge clock);
        check("illegal head ADD", bus.out_instr, 32'h00642820);
        drive(4'd12, 5'd3, 5'd4, 5'd5, 16'h0);
        @(negedge clock);
        exp_emitted++;
        check("illegal err set", 32'(err), 32'd1);
        check("illegal in_ready", 32'(bus.in_ready), 32'd1);
        drive(4'd4, 5'd3, 5'd4, 5'd5, 16'h0);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("illegal head SUB", bus.out_instr, 32'h00642822);
        check("illegal valid SUB", 32'(bus.out_valid), 32'd1);
        @(negedge clock);
        exp_emitted++;
        check("illegal drain", 32'(bus.out_valid), 32'd0);
        check("illegal err held", 32'(err), 32'd1);
        check("illegal emitted", 32'(emitted), 32'(exp_emitted));

        // Asynchronous reset while two words sit in the FIFO.
        bus.out_ready = 1'b0;
        drive(4'd0, 5'd1, 5'd2, 5'd0, 16'h0010);
        @(negedge clock);
        drive(4'd0, 5'd1, 5'd2, 5'd0, 16'h0020);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("mid full", 32'(bus.in_ready), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("mid out_valid", 32'(bus.out_valid), 32'd0);
        check("mid in_ready", 32'(bus.in_ready), 32'd1);
        check("mid err", 32'(err), 32'd0);
        check("mid emitted", 32'(emitted), 32'd0);
        check("mid out_instr", bus.out_instr, 32'h0);
        #1 reset = 1'b1;
        exp_emitted = 0;
        send_one(vecs[0], "post-reset LW");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
